// File: rtl/oled_spi_writer.sv
// SSD1306 4-wire SPI byte writer (mode 0) behind a WRITE_START/WRITE_DONE handshake.
// Build option: define OLED_SPI_LSB_FIRST_EN to shift bytes out LSB first (default MSB first).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for WRITE_START; CS_N high
//   SETUP    | CS_N low, first bit on SDIN, SCLK low for CLK_DIV cycles
//   LOW      | SCLK low for CLK_DIV cycles, next bit on SDIN
//   HIGH     | SCLK high for CLK_DIV cycles (slave samples on the rise)
//   HOLD     | CLK_DIV cycles CS_N low, then CLK_DIV cycles CS_N high
//   DONE     | WRITE_DONE pulse, one cycle
//   WAIT_LOW | wait for the initiator to drop WRITE_START
module oled_spi_writer #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       WRITE_START,
   input  logic [7:0] DATA,
   input  logic       DC_IN,
   output logic       WRITE_DONE,
   output logic       BUSY,
   output logic       OLED_SCLK,
   output logic       OLED_SDIN,
   output logic       OLED_CS_N,
   output logic       OLED_DC
);

   typedef enum logic [2:0] {
      IDLE, SETUP, LOW, HIGH, HOLD, DONE, WAIT_LOW
   } state_t;

   localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

`ifdef OLED_SPI_LSB_FIRST_EN
   localparam bit LSB_FIRST = 1'b1;
`else
   localparam bit LSB_FIRST = 1'b0;
`endif

   state_t     state, state_nxt;
   logic [7:0] div, div_nxt;
   logic [2:0] bit_cnt, bit_cnt_nxt;
   logic [7:0] shreg, shreg_nxt;
   logic       sclk, sclk_nxt;
   logic       sdin, sdin_nxt;
   logic       cs_n, cs_n_nxt;
   logic       dc, dc_nxt;
   logic       done, done_nxt;
   logic       busy, busy_nxt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= IDLE;
         div     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         sclk    <= 1'b0;
         sdin    <= 1'b0;
         cs_n    <= 1'b1;
         dc      <= 1'b0;
         done    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         div     <= div_nxt;
         bit_cnt <= bit_cnt_nxt;
         shreg   <= shreg_nxt;
         sclk    <= sclk_nxt;
         sdin    <= sdin_nxt;
         cs_n    <= cs_n_nxt;
         dc      <= dc_nxt;
         done    <= done_nxt;
         busy    <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      div_nxt     = div;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      sclk_nxt    = sclk;
      sdin_nxt    = sdin;
      cs_n_nxt    = cs_n;
      dc_nxt      = dc;
      done_nxt    = 1'b0;
      busy_nxt    = busy;

      case (state)
         IDLE: begin
            if (WRITE_START) begin
               shreg_nxt   = DATA;
               dc_nxt      = DC_IN;
               cs_n_nxt    = 1'b0;
               busy_nxt    = 1'b1;
               sdin_nxt    = LSB_FIRST ? DATA[0] : DATA[7];
               div_nxt     = DIV_TC;
               bit_cnt_nxt = '0;
               state_nxt   = SETUP;
            end
         end
         SETUP, LOW: begin
            if (div == 8'd0) begin
               sclk_nxt  = 1'b1;
               div_nxt   = DIV_TC;
               state_nxt = HIGH;
            end else begin
               div_nxt = div - 8'd1;
            end
         end
         HIGH: begin
            if (div == 8'd0) begin
               sclk_nxt = 1'b0;
               div_nxt  = DIV_TC;
               if (bit_cnt == 3'd7) begin
                  state_nxt = HOLD;
               end else begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
                  shreg_nxt   = LSB_FIRST ? {1'b0, shreg[7:1]} : {shreg[6:0], 1'b0};
                  sdin_nxt    = LSB_FIRST ? shreg[1] : shreg[6];
                  state_nxt   = LOW;
               end
            end else begin
               div_nxt = div - 8'd1;
            end
         end
         HOLD: begin
            // first terminal count releases CS_N, second one ends the CS_N-high gap
            if (div == 8'd0) begin
               div_nxt = DIV_TC;
               if (!cs_n) begin
                  cs_n_nxt = 1'b1;
               end else begin
                  done_nxt  = 1'b1;
                  state_nxt = DONE;
               end
            end else begin
               div_nxt = div - 8'd1;
            end
         end
         DONE: begin
            state_nxt = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!WRITE_START) begin
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign WRITE_DONE = done;
   assign BUSY       = busy;
   assign OLED_SCLK  = sclk;
   assign OLED_SDIN  = sdin;
   assign OLED_CS_N  = cs_n;
   assign OLED_DC    = dc;

endmodule

// File: tb/tb_oled_spi_writer.sv
// Directed bench for oled_spi_writer: captures SDIN on SCLK rising edges and checks
// bytes, edge counts, handshake timing, retrigger blocking and async reset.
module tb_oled_spi_writer;

`ifdef OLED_SPI_LSB_FIRST_EN
   localparam int D   = 1;
   localparam bit LSB = 1'b1;
`else
   localparam int D   = 4;
   localparam bit LSB = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       WRITE_START;
   logic [7:0] DATA;
   logic       DC_IN;
   logic       WRITE_DONE, BUSY, OLED_SCLK, OLED_SDIN, OLED_CS_N, OLED_DC;

   int n_checks = 0;
   int n_errors = 0;
   int edges    = 0;
   int done_cnt = 0;
   int cs_falls = 0;
   logic [7:0] cap = '0;
   logic       first_bit = 1'b0;

   oled_spi_writer #(.CLK_DIV(D)) dut (
      .CLK(CLK), .RST_N(RST_N), .WRITE_START(WRITE_START), .DATA(DATA), .DC_IN(DC_IN),
      .WRITE_DONE(WRITE_DONE), .BUSY(BUSY), .OLED_SCLK(OLED_SCLK), .OLED_SDIN(OLED_SDIN),
      .OLED_CS_N(OLED_CS_N), .OLED_DC(OLED_DC)
   );

   always #5 CLK = ~CLK;

   always @(posedge OLED_SCLK) begin
      if (edges == 0) first_bit = OLED_SDIN;
      cap   = LSB ? {OLED_SDIN, cap[7:1]} : {cap[6:0], OLED_SDIN};
      edges = edges + 1;
   end

   always @(negedge CLK) if (WRITE_DONE === 1'b1) done_cnt = done_cnt + 1;
   always @(negedge OLED_CS_N) cs_falls = cs_falls + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Starts a transfer and returns 1 ns after the edge that raises WRITE_DONE.
   // DATA/DC_IN are scrambled right after acceptance; drop_at > 0 releases
   // WRITE_START that many cycles after the accepting edge.
   task automatic xfer(input logic [7:0] d, input logic dc, input int drop_at,
                       output int lat, output logic cs_before);
      edges = 0;
      cap   = '0;
      @(negedge CLK);
      DATA = d; DC_IN = dc; WRITE_START = 1'b1;
      @(posedge CLK);
      #1;
      DATA = ~d; DC_IN = ~dc;
      lat = -1;
      cs_before = 1'b0;
      for (int n = 1; n <= 20 * D + 10; n++) begin
         @(posedge CLK);
         #1;
         if (n == drop_at) WRITE_START = 1'b0;
         if (WRITE_DONE) begin
            lat = n;
            break;
         end
         cs_before = OLED_CS_N;
      end
   endtask

   task automatic release_start();
      @(negedge CLK);
      WRITE_START = 1'b0;
      repeat (3) @(negedge CLK);
   endtask

   initial begin
      int   lat, d0, f0, bad, rst_at;
      logic csb, b1, b2;

      RST_N = 1'b1; WRITE_START = 1'b0; DATA = '0; DC_IN = 1'b0;
      #3 RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_cs_n", OLED_CS_N, 1);
      chk("rst_sclk", OLED_SCLK, 0);
      chk("rst_sdin", OLED_SDIN, 0);
      chk("rst_done", WRITE_DONE, 0);
      chk("rst_busy", BUSY, 0);
      @(negedge CLK) RST_N = 1'b1;

      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (OLED_CS_N !== 1'b1 || OLED_SCLK !== 1'b0 || OLED_SDIN !== 1'b0 ||
             WRITE_DONE !== 1'b0 || BUSY !== 1'b0) bad++;
      end
      chk("idle_quiet", bad, 0);

      // 0xAE command byte, start released one cycle after the done pulse
      d0 = done_cnt; f0 = cs_falls;
      xfer(8'hAE, 1'b0, 0, lat, csb);
      chk("ae_latency", lat, 18 * D);
      chk("ae_cs_high_before_done", csb, 1);
      chk("ae_busy_at_done", BUSY, 1);
      release_start();
      chk("ae_byte", cap, 8'hAE);
      chk("ae_edges", edges, 8);
      chk("ae_dc", OLED_DC, 0);
      chk("ae_done_pulses", done_cnt - d0, 1);
      chk("ae_busy_after", BUSY, 0);

      // start held 5 cycles past done must not retrigger
      d0 = done_cnt; f0 = cs_falls;
      xfer(8'h5A, 1'b0, 0, lat, csb);
      repeat (5) @(negedge CLK);
      chk("hold_busy", BUSY, 1);
      chk("hold_cs_falls", cs_falls - f0, 1);
      chk("hold_cs_n", OLED_CS_N, 1);
      release_start();
      chk("hold_done_pulses", done_cnt - d0, 1);

      xfer(8'hA5, 1'b1, 0, lat, csb);
      release_start();
      chk("a5_byte", cap, 8'hA5);
      chk("a5_dc", OLED_DC, 1);
      chk("a5_latency", lat, 18 * D);

      // start dropped mid-transfer: completes, then IDLE right after WAIT_LOW
      d0 = done_cnt;
      xfer(8'h3C, 1'b0, (20 * D) / 4, lat, csb);
      chk("3c_latency", lat, 18 * D);
      @(posedge CLK); #1 b1 = BUSY;
      @(posedge CLK); #1 b2 = BUSY;
      chk("3c_busy_wait_low", b1, 1);
      chk("3c_busy_idle", b2, 0);
      chk("3c_byte", cap, 8'h3C);
      chk("3c_done_pulses", done_cnt - d0, 1);

      // async reset mid-transfer
      rst_at = (30 * D) / 4;
      d0 = done_cnt;
      @(negedge CLK);
      DATA = 8'hFF; DC_IN = 1'b1; WRITE_START = 1'b1;
      @(posedge CLK);
      repeat (rst_at) @(posedge CLK);
      #2 RST_N = 1'b0; WRITE_START = 1'b0;
      #1;
      chk("mid_rst_cs_n", OLED_CS_N, 1);
      chk("mid_rst_sclk", OLED_SCLK, 0);
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_dc", OLED_DC, 0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      repeat (20 * D) @(negedge CLK);
      chk("mid_rst_no_done", done_cnt - d0, 0);

      xfer(8'h81, 1'b0, 0, lat, csb);
      release_start();
      chk("81_byte", cap, 8'h81);
      chk("81_edges", edges, 8);
      chk("81_latency", lat, 18 * D);

      xfer(8'h01, 1'b1, 0, lat, csb);
      release_start();
      chk("01_first_bit", first_bit, LSB ? 1 : 0);
      chk("01_byte", cap, 8'h01);
      chk("01_latency", lat, 18 * D);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
